// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-flow controller.
//   game_state_t  - controller FSM states
//   LVL_*         - level encodings fed to the countdown timer
//   MAX_TOTAL     - saturation value for the per-game won-round total
//   coerce_level  - maps the unused level code 2'b00 onto LVL_EASY
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_PAUSE,
        S_OVER,
        S_WIN
    } game_state_t;

    localparam logic [1:0] LVL_EASY  = 2'b01;
    localparam logic [1:0] LVL_MED   = 2'b10;
    localparam logic [1:0] LVL_HARD  = 2'b11;
    localparam logic [3:0] MAX_TOTAL = 4'd9;

    function automatic logic [1:0] coerce_level(input logic [1:0] lvl);
        return (lvl == 2'b00) ? LVL_EASY : lvl;
    endfunction

endpackage

// File: rtl/game_timer_ctrl_round_tracker.sv
// round_tracker: holds the level and round counters for one game session.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (all counters 0)
//   clr_i             - start of game: load level from start_level_i, clear counts
//   start_level_i[1:0]- requested starting level (00 treated as easy)
//   win_i             - one won round; advances counters
//   round_count_o[3:0]- rounds won at the current level
//   total_rounds_o[3:0]- rounds won this game, saturating at MAX_TOTAL
//   game_level_o[1:0] - current level
//   last_round_o      - the current round is the final round of the hardest level
module round_tracker
    import game_pkg::*;
#(
    parameter int ROUNDS_PER_LEVEL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic [1:0] start_level_i,
    input  logic       win_i,
    output logic [3:0] round_count_o,
    output logic [3:0] total_rounds_o,
    output logic [1:0] game_level_o,
    output logic       last_round_o
);

    localparam logic [3:0] LAST_RC = 4'(ROUNDS_PER_LEVEL - 1);

    logic [3:0] round_q, round_d;
    logic [3:0] total_q, total_d;
    logic [1:0] level_q, level_d;

    always_comb begin
        round_d = round_q;
        total_d = total_q;
        level_d = level_q;
        if (clr_i) begin
            round_d = 4'd0;
            total_d = 4'd0;
            level_d = coerce_level(start_level_i);
        end else if (win_i) begin
            total_d = (total_q >= MAX_TOTAL) ? MAX_TOTAL : total_q + 4'd1;
            if (round_q < LAST_RC) begin
                round_d = round_q + 4'd1;
            end else if (level_q < LVL_HARD) begin
                level_d = level_q + 2'd1;
                round_d = 4'd0;
            end
            // Final round of the hardest level: the FSM moves to WIN and the
            // level/round counters are left as they are.
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= 4'd0;
            total_q <= 4'd0;
            level_q <= 2'b00;
        end else begin
            round_q <= round_d;
            total_q <= total_d;
            level_q <= level_d;
        end
    end

    assign round_count_o  = round_q;
    assign total_rounds_o = total_q;
    assign game_level_o   = level_q;
    assign last_round_o   = (level_q == LVL_HARD) && (round_q >= LAST_RC);

endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: sequences the countdown timer through a game session.
// Reloads (LOAD) and settles (ARM) the timer before each round, enables
// counting in RUN, freezes it in PAUSE, and ends the game in OVER or WIN.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   startGame, pauseToggle   - single-cycle control pulses
//   roundWon, roundLost      - single-cycle round result pulses
//   startLevel[1:0]          - level latched when a game starts
//   timeout                  - timer reads 00 (level)
//   timerReconfig            - timer reload strobe (LOAD)
//   timerEnable              - timer count enable (RUN)
//   gameLevel[1:0]           - current level to timer
//   roundCount, totalRounds  - won-round counters
//   playing/paused/gameOver/gameWon - state flags
// All outputs are decoded from registers only.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS_PER_LEVEL = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startGame,
    input  logic       pauseToggle,
    input  logic       roundWon,
    input  logic       roundLost,
    input  logic [1:0] startLevel,
    input  logic       timeout,
    output logic       timerReconfig,
    output logic       timerEnable,
    output logic [1:0] gameLevel,
    output logic [3:0] roundCount,
    output logic [3:0] totalRounds,
    output logic       playing,
    output logic       paused,
    output logic       gameOver,
    output logic       gameWon
);

    game_state_t state_q, state_d;
    logic        clr, win, last_round;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        win     = 1'b0;
        unique case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (startGame) begin
                    clr     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_ARM;
            S_ARM:  state_d = S_RUN;
            S_RUN: begin
                // Only the highest-priority active input acts.
                if (timeout || roundLost) begin
                    state_d = S_OVER;
                end else if (roundWon) begin
                    win     = 1'b1;
                    state_d = last_round ? S_WIN : S_LOAD;
                end else if (pauseToggle) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: if (pauseToggle) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    round_tracker #(.ROUNDS_PER_LEVEL(ROUNDS_PER_LEVEL)) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr),
        .start_level_i (startLevel),
        .win_i         (win),
        .round_count_o (roundCount),
        .total_rounds_o(totalRounds),
        .game_level_o  (gameLevel),
        .last_round_o  (last_round)
    );

    assign timerReconfig = (state_q == S_LOAD);
    assign timerEnable   = (state_q == S_RUN);
    assign playing       = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_RUN);
    assign paused        = (state_q == S_PAUSE);
    assign gameOver      = (state_q == S_OVER);
    assign gameWon       = (state_q == S_WIN);

endmodule

// File: tb/tb_game_timer_ctrl.sv
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst, startGame, pauseToggle, roundWon, roundLost, timeout;
    logic [1:0] startLevel;
    logic       timerReconfig, timerEnable, playing, paused, gameOver, gameWon;
    logic [1:0] gameLevel;
    logic [3:0] roundCount, totalRounds;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_timer_ctrl #(.ROUNDS_PER_LEVEL(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .startGame    (startGame),
        .pauseToggle  (pauseToggle),
        .roundWon     (roundWon),
        .roundLost    (roundLost),
        .startLevel   (startLevel),
        .timeout      (timeout),
        .timerReconfig(timerReconfig),
        .timerEnable  (timerEnable),
        .gameLevel    (gameLevel),
        .roundCount   (roundCount),
        .totalRounds  (totalRounds),
        .playing      (playing),
        .paused       (paused),
        .gameOver     (gameOver),
        .gameWon      (gameWon)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // one clock; inputs set after this are sampled at the next edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {reconfig, enable, level, rc, total, playing, paused, over, won}
    function automatic logic [31:0] outs();
        return {13'd0, timerReconfig, timerEnable, gameLevel, roundCount, totalRounds,
                playing, paused, gameOver, gameWon};
    endfunction

    function automatic logic [31:0] mk(input logic rc_, input logic en, input logic [1:0] lv,
                                       input logic [3:0] r, input logic [3:0] t,
                                       input logic pl, input logic pa, input logic ov,
                                       input logic wn);
        return {13'd0, rc_, en, lv, r, t, pl, pa, ov, wn};
    endfunction

    // won round that stays in play: LOAD, ARM, then RUN again
    task automatic win_round(input string tag, input logic [1:0] lv, input logic [3:0] r,
                             input logic [3:0] t);
        roundWon = 1'b1; step(); roundWon = 1'b0;
        chk({tag, "_load"}, outs(), mk(1, 0, lv, r, t, 1, 0, 0, 0));
        step();
        chk({tag, "_arm"},  outs(), mk(0, 0, lv, r, t, 1, 0, 0, 0));
        step();
        chk({tag, "_run"},  outs(), mk(0, 1, lv, r, t, 1, 0, 0, 0));
    endtask

    initial begin
        rst = 1'b1; startGame = 0; pauseToggle = 0; roundWon = 0; roundLost = 0;
        timeout = 0; startLevel = 2'b00;
        step(); step();
        chk("reset", outs(), 32'd0);
        rst = 1'b0;
        step();
        chk("idle", outs(), 32'd0);

        // start at level 00 -> coerced to 01
        startGame = 1'b1; step(); startGame = 1'b0;
        chk("n1_load", outs(), mk(1, 0, 2'b01, 0, 0, 1, 0, 0, 0));
        step();
        chk("n2_arm",  outs(), mk(0, 0, 2'b01, 0, 0, 1, 0, 0, 0));
        step();
        chk("n3_run",  outs(), mk(0, 1, 2'b01, 0, 0, 1, 0, 0, 0));

        // startGame ignored in RUN
        startGame = 1'b1; step(); startGame = 1'b0;
        chk("start_ign", outs(), mk(0, 1, 2'b01, 0, 0, 1, 0, 0, 0));

        win_round("w1", 2'b01, 4'd1, 4'd1);
        win_round("w2", 2'b01, 4'd2, 4'd2);
        win_round("w3", 2'b10, 4'd0, 4'd3);

        // pause, ignored roundLost/timeout, resume without reload
        pauseToggle = 1'b1; step(); pauseToggle = 1'b0;
        chk("pause", outs(), mk(0, 0, 2'b10, 0, 3, 0, 1, 0, 0));
        roundLost = 1'b1; timeout = 1'b1; step(); roundLost = 1'b0; timeout = 1'b0;
        chk("pause_lost", outs(), mk(0, 0, 2'b10, 0, 3, 0, 1, 0, 0));
        pauseToggle = 1'b1; step(); pauseToggle = 1'b0;
        chk("resume", outs(), mk(0, 1, 2'b10, 0, 3, 1, 0, 0, 0));

        win_round("w4", 2'b10, 4'd1, 4'd4);
        win_round("w5", 2'b10, 4'd2, 4'd5);

        // reset mid-round
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_run", outs(), 32'd0);

        // level 3 run to WIN
        startLevel = 2'b11; startGame = 1'b1; step(); startGame = 1'b0;
        chk("l3_load", outs(), mk(1, 0, 2'b11, 0, 0, 1, 0, 0, 0));
        step(); step();
        win_round("h1", 2'b11, 4'd1, 4'd1);
        win_round("h2", 2'b11, 4'd2, 4'd2);
        roundWon = 1'b1; step(); roundWon = 1'b0;
        chk("win", outs(), mk(0, 0, 2'b11, 2, 3, 0, 0, 0, 1));
        roundWon = 1'b1; pauseToggle = 1'b1; step(); roundWon = 1'b0; pauseToggle = 1'b0;
        chk("win_frozen", outs(), mk(0, 0, 2'b11, 2, 3, 0, 0, 0, 1));

        // restart from WIN
        startLevel = 2'b11; startGame = 1'b1; step(); startGame = 1'b0;
        chk("restart", outs(), mk(1, 0, 2'b11, 0, 0, 1, 0, 0, 0));
        step(); step();
        chk("restart_run", outs(), mk(0, 1, 2'b11, 0, 0, 1, 0, 0, 0));

        // timeout beats roundWon
        timeout = 1'b1; roundWon = 1'b1; step(); timeout = 1'b0; roundWon = 1'b0;
        chk("timeout", outs(), mk(0, 0, 2'b11, 0, 0, 0, 0, 1, 0));

        // restart from OVER at level 2, then lose a round
        startLevel = 2'b10; startGame = 1'b1; step(); startGame = 1'b0;
        chk("over_restart", outs(), mk(1, 0, 2'b10, 0, 0, 1, 0, 0, 0));
        step(); step();
        roundLost = 1'b1; roundWon = 1'b1; step(); roundLost = 1'b0; roundWon = 1'b0;
        chk("lost", outs(), mk(0, 0, 2'b10, 0, 0, 0, 0, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
